// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Burst read controller sitting between a synchronous FIFO read port (read
// latency of one cycle) and a valid/ready output stream. A burst command of
// `len` bytes is accepted in IDLE. The controller then issues FIFO reads and
// captures each byte into a 2-entry skid buffer, which feeds the stream. The
// final byte of the burst is flagged with m_last. After that byte is handed
// over, done pulses for one cycle and the controller returns to IDLE.
//
// Optional feature (macro FIFO_RD_CHECKSUM_EN):
//   Adds output csum, the XOR of every byte handed over in the current burst.
//   csum is valid while done=1. It is cleared at burst start and on reset.
//   When the macro is undefined, the port and its logic are absent.
//
// Ports:
//   clk         in   single clock, all logic on posedge
//   reset       in   synchronous, active-high reset (has priority over start)
//   start, len  in   burst command, sampled in IDLE when start=1
//   fifo_empty  in   FIFO has no data
//   fifo_rd_en  out  FIFO read strobe; data is returned on the next cycle
//   fifo_data   in   FIFO read data
//   m_valid     out  stream valid (output buffer non-empty)
//   m_data      out  stream data (oldest buffered byte)
//   m_last      out  marks the len-th byte of the burst
//   m_ready     in   stream ready
//   busy        out  high in RUN and DONE
//   done        out  one-cycle pulse after the final handshake
//   cmd_err     out  one-cycle pulse for a start with len=0 or len>MAX_BURST
//   csum        out  burst checksum (only with FIFO_RD_CHECKSUM_EN)
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        len,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
`ifdef FIFO_RD_CHECKSUM_EN
    output logic              cmd_err,
    output logic [DATA_W-1:0] csum
`else
    output logic              cmd_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] MAX_LEN = 5'(MAX_BURST);

    state_t            state_q;
    state_t            state_d;

    logic [4:0]        len_q;          // latched burst length
    logic [4:0]        rd_cnt;         // FIFO reads issued in this burst
    logic              inflight;       // a read was issued last cycle
    logic              inflight_last;  // ...and it fetches the final byte
    logic [1:0]        buf_cnt;        // occupied output buffer entries
    logic [DATA_W-1:0] buf_data [2];   // entry 0 is always the oldest
    logic              buf_last [2];
    logic              cmd_err_q;

    logic              cmd_ok;
    logic              start_ok;
    logic              start_bad;
    logic              pop;
    logic              push;
    logic              room;
    logic [1:0]        wr_slot;

    // -------------------------------------------------------------------------
    // Command decode and buffer handshakes
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so
        // no path can leave it unassigned and infer a latch.
        cmd_ok    = 1'b0;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        cmd_ok    = (len != 5'd0) && (len <= MAX_LEN);
        // Commands are only looked at in IDLE; start in RUN/DONE is ignored.
        start_ok  = (state_q == IDLE) && start && cmd_ok;
        start_bad = (state_q == IDLE) && start && !cmd_ok;
    end

    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = buf_data[0];
    assign m_last  = buf_last[0];
    assign pop     = m_valid && m_ready;
    assign push    = inflight;
    // Reads in flight plus bytes already buffered must fit the 2-entry buffer.
    assign room    = (({1'b0, inflight} + buf_cnt) < 2'd2);
    // After an optional pop shifts entry 1 down, the new byte lands in the
    // first free slot.
    assign wr_slot = buf_cnt - {1'b0, pop};

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (pop && m_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        fifo_rd_en = 1'b0;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        // Gated by reset as well, so a reset cycle never pops a byte that
        // would then be discarded.
        fifo_rd_en = !reset && (state_q == RUN) && !fifo_empty &&
                     (rd_cnt < len_q) && room;
    end

    // -------------------------------------------------------------------------
    // Counters, in-flight tracking and output buffer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the two buffer entries are reset explicitly because m_data and
        // m_last must read zero straight out of reset; larger storage that
        // is never observed before being written would be left unreset.
        if (reset) begin
            len_q         <= 5'd0;
            rd_cnt        <= 5'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            buf_cnt       <= 2'd0;
            buf_data[0]   <= '0;
            buf_data[1]   <= '0;
            buf_last[0]   <= 1'b0;
            buf_last[1]   <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            cmd_err_q <= start_bad;

            if (start_ok) begin
                len_q  <= len;
                rd_cnt <= 5'd0;
            end else if (fifo_rd_en) begin
                rd_cnt <= rd_cnt + 5'd1;
            end

            // The last flag is decided when the read is issued. It then
            // travels with the byte through the buffer.
            inflight <= fifo_rd_en;
            if (fifo_rd_en) begin
                inflight_last <= ((rd_cnt + 5'd1) == len_q);
            end

            buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};

            if (pop) begin
                buf_data[0] <= buf_data[1];
                buf_last[0] <= buf_last[1];
            end
            // A later write to the same entry overrides the shift above.
            if (push) begin
                buf_data[wr_slot[0]] <= fifo_data;
                buf_last[wr_slot[0]] <= inflight_last;
            end
        end
    end

    assign cmd_err = cmd_err_q;

`ifdef FIFO_RD_CHECKSUM_EN
    // -------------------------------------------------------------------------
    // Burst checksum: XOR of every byte accepted by the stream sink
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if (pop) begin
            csum_q <= csum_q ^ m_data;
        end
    end

    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//
// Self-checking bench for fifo_rd_ctrl. A FIFO model with one-cycle read
// latency feeds the DUT. The expected stream is the list of bytes the
// scenario intends to send: a burst of len bytes must produce exactly those
// bytes, in order. m_last must appear only on the final byte, and done must
// pulse one cycle after that byte's handshake. Inputs change 1 time unit after
// posedge. Outputs are sampled on negedge.
// Define FIFO_RD_CHECKSUM_EN to also check csum.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [4:0]        len;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_data;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;
    logic              busy;
    logic              done;
    logic              cmd_err;
`ifdef FIFO_RD_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    fifo_rd_ctrl #(.DATA_W(DATA_W), .MAX_BURST(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
`ifdef FIFO_RD_CHECKSUM_EN
        .cmd_err    (cmd_err),
        .csum       (csum)
`else
        .cmd_err    (cmd_err)
`endif
    );

    always #5 clk = ~clk;

    // Bench state
    int                tests;
    int                fails;
    logic [DATA_W-1:0] src_q [$];   // every byte ever written into the FIFO
    int                rd_ptr;      // next FIFO entry to be read
    logic [DATA_W-1:0] exp_q [$];   // bytes still expected on the stream
    logic [DATA_W-1:0] csum_exp;
    bit                done_exp;
    bit                hold_pending;
    logic [DATA_W-1:0] hold_data;
    logic              hold_last;
    bit                rd_now;
    int                rx_cnt;
    int                rd_pulses;
    int                err_pulses;
    bit                s_done, s_busy, s_valid, s_err;

    // One clock cycle: check the stream at negedge, then advance the FIFO model
    // just after posedge.
    task automatic step();
        bit hs;
        @(negedge clk);
        s_done = 1'b0; s_busy = 1'b0; s_valid = 1'b0; s_err = 1'b0;
        rd_now = 1'b0;
        if (reset) begin
            // Everything in flight is discarded by the reset edge.
            exp_q.delete();
            hold_pending = 1'b0;
            done_exp     = 1'b0;
            rd_ptr       = src_q.size();
        end else begin
            s_done = done; s_busy = busy; s_valid = m_valid; s_err = cmd_err;

            tests++;
            if (done !== done_exp) begin
                fails++;
                $display("FAIL done_timing: done=%b expected %b at %0t", done, done_exp, $time);
            end
`ifdef FIFO_RD_CHECKSUM_EN
            if (done_exp) begin
                tests++;
                if (csum !== csum_exp) begin
                    fails++;
                    $display("FAIL csum: got %h expected %h", csum, csum_exp);
                end
            end
`endif
            if (hold_pending) begin
                tests++;
                if (m_valid !== 1'b1 || m_data !== hold_data || m_last !== hold_last) begin
                    fails++;
                    $display("FAIL hold_stable: valid=%b data=%h last=%b expected 1/%h/%b",
                             m_valid, m_data, m_last, hold_data, hold_last);
                end
            end
            tests++;
            if (fifo_rd_en === 1'b1 && fifo_empty) begin
                fails++;
                $display("FAIL underflow: fifo_rd_en=1 while fifo_empty=1 at %0t", $time);
            end

            hs       = m_valid && m_ready;
            done_exp = 1'b0;
            if (m_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_valid: m_valid=1 data=%h with no byte expected", m_data);
                end else if (hs) begin
                    tests++;
                    if (m_data !== exp_q[0] || m_last !== (exp_q.size() == 1)) begin
                        fails++;
                        $display("FAIL stream_byte: data=%h last=%b expected %h/%b",
                                 m_data, m_last, exp_q[0], (exp_q.size() == 1));
                    end
                    done_exp = (exp_q.size() == 1);
                    void'(exp_q.pop_front());
                    rx_cnt++;
                end
            end
            hold_pending = m_valid && !m_ready;
            hold_data    = m_data;
            hold_last    = m_last;
            rd_now       = (fifo_rd_en === 1'b1);
            if (rd_now) rd_pulses++;
            if (cmd_err === 1'b1) err_pulses++;
        end
        @(posedge clk);
        #1;
        if (rd_now && rd_ptr < src_q.size()) begin
            fifo_data = src_q[rd_ptr];
            rd_ptr++;
        end
        fifo_empty = (rd_ptr >= src_q.size());
    endtask

    task automatic push(input logic [DATA_W-1:0] b);
        src_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic start_cmd(input logic [4:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            step();
            if (s_done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;     // reset must win over start
        len   = 5'd3;
        step();
        step();
        start = 1'b0;
        tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
        tests++; if (m_data !== '0) begin fails++; $display("FAIL reset_data: got %h expected 00", m_data); end
        tests++; if (m_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b expected 0", m_last); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL reset_cmd_err: got %b expected 0", cmd_err); end
`ifdef FIFO_RD_CHECKSUM_EN
        tests++; if (csum !== '0) begin fails++; $display("FAIL reset_csum: got %h expected 00", csum); end
`endif
        reset = 1'b0;
        step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_priority: busy=%b expected 0 after start under reset", busy);
        end
    endtask

    task automatic test_basic();
        bit seen;
        int rx0;
        exp_q    = '{8'h24, 8'h81, 8'h09};
        csum_exp = 8'hAC;
        push(8'h24); push(8'h81); push(8'h09);
        m_ready = 1'b1;
        rx0 = rx_cnt;
        start_cmd(5'd3);
        wait_done(40, seen);
        tests++;
        if (!seen) begin fails++; $display("FAIL basic_done: done seen=%b expected 1", seen); end
        tests++;
        if (rx_cnt - rx0 != 3) begin fails++; $display("FAIL basic_count: got %0d bytes expected 3", rx_cnt - rx0); end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle: busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        int rx0, p0;
        logic [DATA_W-1:0] b [4];
        exp_q.delete();
        csum_exp = '0;
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom);
            push(b[i]);
            exp_q.push_back(b[i]);
            csum_exp ^= b[i];
        end
        m_ready = 1'b0;
        rx0 = rx_cnt;
        start_cmd(5'd4);
        p0 = rd_pulses;
        repeat (6) step();
        tests++;
        if (rd_pulses - p0 != 2) begin
            fails++;
            $display("FAIL bp_reads: got %0d fifo_rd_en pulses expected 2", rd_pulses - p0);
        end
        tests++;
        if (m_valid !== 1'b1 || m_data !== b[0]) begin
            fails++;
            $display("FAIL bp_head: valid=%b data=%h expected 1/%h", m_valid, m_data, b[0]);
        end
        m_ready = 1'b1;
        wait_done(40, seen);
        tests++;
        if (!seen || rx_cnt - rx0 != 4) begin
            fails++;
            $display("FAIL bp_complete: done=%b bytes=%0d expected 1/4", seen, rx_cnt - rx0);
        end
    endtask

    task automatic test_empty_stall();
        bit seen;
        int rx0, p0, bad;
        logic [DATA_W-1:0] b0, b1;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        exp_q    = '{b0, b1};
        csum_exp = b0 ^ b1;
        m_ready  = 1'b1;
        rx0 = rx_cnt;
        start_cmd(5'd2);
        p0  = rd_pulses;
        bad = 0;
        repeat (8) begin
            step();
            if (s_busy !== 1'b1) bad++;
        end
        tests++;
        if (rd_pulses != p0 || bad != 0) begin
            fails++;
            $display("FAIL stall_idle: reads=%0d busy_low=%0d expected 0/0", rd_pulses - p0, bad);
        end
        push(b0);
        repeat (4) step();
        tests++;
        if (rd_pulses - p0 != 1 || busy !== 1'b1 || rx_cnt - rx0 != 1) begin
            fails++;
            $display("FAIL stall_one: reads=%0d busy=%b bytes=%0d expected 1/1/1",
                     rd_pulses - p0, busy, rx_cnt - rx0);
        end
        push(b1);
        wait_done(40, seen);
        tests++;
        if (!seen || rx_cnt - rx0 != 2) begin
            fails++;
            $display("FAIL stall_complete: done=%b bytes=%0d expected 1/2", seen, rx_cnt - rx0);
        end
    endtask

    task automatic test_bad_cmd();
        logic [4:0] bad_len [2];
        int e0, p0, busy_hi;
        bad_len[0] = 5'd0;
        bad_len[1] = 5'd17;
        // Data waiting in the FIFO makes a stray read observable.
        push(8'h5A); push(8'hA5);
        exp_q.delete();
        m_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e0 = err_pulses;
            p0 = rd_pulses;
            busy_hi = 0;
            start_cmd(bad_len[k]);
            repeat (4) begin
                step();
                if (s_busy !== 1'b0) busy_hi++;
            end
            tests++;
            if (err_pulses - e0 != 1) begin
                fails++;
                $display("FAIL bad_cmd_err len=%0d: %0d cmd_err cycles expected 1", bad_len[k], err_pulses - e0);
            end
            tests++;
            if (busy_hi != 0 || rd_pulses != p0) begin
                fails++;
                $display("FAIL bad_cmd_quiet len=%0d: busy cycles=%0d reads=%0d expected 0/0",
                         bad_len[k], busy_hi, rd_pulses - p0);
            end
        end
        rd_ptr     = src_q.size();
        fifo_empty = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit seen;
        int rx0, vcnt;
        logic [DATA_W-1:0] b;
        exp_q.delete();
        csum_exp = '0;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            push(b);
            exp_q.push_back(b);
            csum_exp ^= b;
        end
        m_ready = 1'b1;
        rx0 = rx_cnt;
        start_cmd(5'd16);
        for (int i = 0; i < 100 && (rx_cnt - rx0) < 5; i++) step();
        tests++;
        if (rx_cnt - rx0 != 5) begin
            fails++;
            $display("FAIL rst_mid_progress: %0d handshakes expected 5", rx_cnt - rx0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_outputs: rd=%b v=%b d=%h l=%b busy=%b done=%b err=%b expected all 0",
                     fifo_rd_en, m_valid, m_data, m_last, busy, done, cmd_err);
        end
`ifdef FIFO_RD_CHECKSUM_EN
        tests++;
        if (csum !== '0) begin fails++; $display("FAIL rst_mid_csum: got %h expected 00", csum); end
`endif
        vcnt = 0;
        repeat (8) begin
            step();
            if (s_valid !== 1'b0) vcnt++;
        end
        tests++;
        if (vcnt != 0) begin fails++; $display("FAIL rst_mid_silent: m_valid high %0d cycles expected 0", vcnt); end
        b        = 8'($urandom);
        exp_q    = '{b};
        csum_exp = b;
        push(b);
        rx0 = rx_cnt;
        start_cmd(5'd1);
        wait_done(40, seen);
        tests++;
        if (!seen || rx_cnt - rx0 != 1) begin
            fails++;
            $display("FAIL rst_mid_after: done=%b bytes=%0d expected 1/1", seen, rx_cnt - rx0);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] b [16];
        int l, pre, nxt, rx0, errs;
        bit seen;
        for (int it = 0; it < 25; it++) begin
            l = $urandom_range(1, 16);
            exp_q.delete();
            csum_exp = '0;
            for (int i = 0; i < l; i++) begin
                b[i] = 8'($urandom);
                exp_q.push_back(b[i]);
                csum_exp ^= b[i];
            end
            pre = $urandom_range(0, l);
            for (int i = 0; i < pre; i++) push(b[i]);
            nxt     = pre;
            m_ready = 1'($urandom_range(0, 1));
            rx0     = rx_cnt;
            start_cmd(5'(l));
            seen = 1'b0;
            errs = 0;
            for (int c = 0; c < 600 && !seen; c++) begin
                m_ready = ($urandom_range(0, 3) != 0);
                if (nxt < l && $urandom_range(0, 1) == 1) begin
                    push(b[nxt]);
                    nxt++;
                end
                // Stray commands while busy must be ignored.
                start = ($urandom_range(0, 4) == 0);
                len   = 5'($urandom_range(0, 31));
                step();
                if (s_err) errs++;
                if (s_done) seen = 1'b1;
            end
            start = 1'b0;
            step();
            if (s_err) errs++;
            tests++;
            if (!seen || errs != 0 || rx_cnt - rx0 != l || exp_q.size() != 0) begin
                fails++;
                $display("FAIL random it=%0d len=%0d: done=%b cmd_err=%0d bytes=%0d left=%0d expected 1/0/%0d/0",
                         it, l, seen, errs, rx_cnt - rx0, exp_q.size(), l);
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rd_ptr = 0; rx_cnt = 0; rd_pulses = 0; err_pulses = 0;
        done_exp = 1'b0; hold_pending = 1'b0; csum_exp = '0;
        reset = 1'b1; start = 1'b0; len = 5'd0;
        fifo_empty = 1'b1; fifo_data = '0; m_ready = 1'b0;

        test_reset();
        test_basic();
        test_backpressure();
        test_empty_stall();
        test_bad_cmd();
        test_reset_mid();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, 8, data width of the FIFO read port and output stream.
REQ-002 SHALL have parameter MAX_BURST, 16, largest burst length accepted (matches FIFO depth).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports start (input, 1) and len (input, 5), a burst command of len bytes, sampled when start=1.
REQ-006 SHALL have ports fifo_empty (input, 1), fifo_rd_en (output, 1) and fifo_data (input, DATA_W), connecting to the FIFO read side.
REQ-007 SHALL have ports m_valid (output, 1), m_data (output, DATA_W), m_last (output, 1) and m_ready (input, 1), forming the output stream.
REQ-008 SHALL have ports busy (output, 1), done (output, 1) and cmd_err (output, 1), reporting status.

Function
REQ-009 SHALL implement FSM states IDLE, RUN and DONE.
REQ-010 SHALL, in IDLE with start=1 and 1<=len<=MAX_BURST, latch len and go to RUN next cycle.
REQ-011 SHALL, in IDLE with start=1 and len=0 or len>MAX_BURST, stay IDLE and pulse cmd_err for exactly one cycle.
REQ-012 SHALL ignore start in RUN and DONE: no error pulse and no change to the latched length.
REQ-013 SHALL assume FIFO read latency of 1: fifo_data is valid the cycle after fifo_rd_en=1, and is captured then.
REQ-014 SHALL assert fifo_rd_en only in RUN, only when fifo_empty=0, only while reads issued < len, and only while in-flight reads + buffered bytes < 2.
REQ-015 SHALL never assert fifo_rd_en while fifo_empty=1; no underflow reads.
REQ-016 SHALL hold captured bytes in a 2-entry output buffer, in FIFO order.
REQ-017 SHALL drive m_valid=1 whenever the buffer is non-empty, with m_data = oldest entry.
REQ-018 SHALL keep m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-019 SHALL count a transfer on m_valid&&m_ready, and accept a simultaneous capture and pop in the same cycle.
REQ-020 SHALL assert m_last with the len-th byte of the burst only.
REQ-021 SHALL go RUN->DONE on the cycle after the final handshake, pulse done=1 in DONE for one cycle, then go to IDLE.
REQ-022 SHALL assert busy=1 in RUN and DONE, and busy=0 in IDLE.
REQ-023 SHALL, if fifo_empty stays 1 mid-burst, stall in RUN indefinitely with busy=1; there is no timeout.
REQ-024 SHALL track its counters in 5 bits, without wrap, since the limit is MAX_BURST=16.

Reset
REQ-025 SHALL, with reset=1 at a clock edge, enter IDLE, clear the buffer, counters and in-flight flag, and drive fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, cmd_err=0.
REQ-026 SHALL, on reset mid-burst, discard the in-flight read and buffered data; nothing is emitted after reset.
REQ-027 SHALL give reset priority over start.

Configuration
REQ-028 SHALL, with macro FIFO_RD_CHECKSUM_EN defined, add output csum (DATA_W), the XOR of all bytes handed over in the burst; csum is valid while done=1, cleared at burst start and on reset.
REQ-029 SHALL, without FIFO_RD_CHECKSUM_EN, omit the csum port and its logic entirely; all other behaviour is identical.

Verification
REQ-030 SHALL check basic burst: FIFO model holds 0x24,0x81,0x09; start, len=3; m_ready=1 -> m_data 0x24,0x81,0x09 in order, m_last only on 0x09, done one cycle after the last handshake, csum=0xAC when the macro is defined.
REQ-031 SHALL check backpressure: len=4, FIFO full, m_ready=0 for 6 cycles -> exactly 2 fifo_rd_en pulses, m_data held at the first byte; after m_ready=1 all 4 bytes arrive in order.
REQ-032 SHALL check empty stall: len=2, fifo_empty=1 for 8 cycles -> fifo_rd_en=0 throughout, busy=1; then one write -> one read, busy still 1 until the 2nd byte.
REQ-033 SHALL check bad commands: len=0, then len=17 -> cmd_err one-cycle pulse each, busy stays 0, no fifo_rd_en.
REQ-034 SHALL check reset mid-burst: len=16, reset after 5 handshakes -> all outputs at reset values next cycle, no further m_valid; a new len=1 burst then completes normally.
